ib_queue: RTL and testbench

//  Parametrised instruction buffer between I$ fetch and dual/multi-issue ID stage.

---
 rtl/ib_queue.sv | 99 +++++++++
 tb/tb_ib_queue.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ib_queue.sv
// ib_queue: compacting fetch-to-ID instruction buffer; define IB_DELOT_PAIR_EN to hold predicted branches until their delay slot can issue alongside
module ib_queue #(
    parameter int FETCH_W = 4,
    parameter int ISSUE_W = 2,
    parameter int DEPTH   = 16,
    parameter int PTAB_W  = 5
) (
    input  logic                         clk,
    input  logic                         rst_,
    input  logic                         flush,
    input  logic                         fetch_valid,
    input  logic [31:0]                  fetch_pc,
    input  logic [FETCH_W*32-1:0]        fetch_insn,
    input  logic [FETCH_W-1:0]           fetch_mask,
    input  logic [FETCH_W-1:0]           fetch_delot,
    input  logic [PTAB_W-1:0]            fetch_ptab_addr,
    input  logic [31:0]                  fetch_branch_pc,
    output logic                         ib_allin,
    output logic [ISSUE_W-1:0]           ib_id_valid,
    output logic [ISSUE_W*32-1:0]        ib_id_pc,
    output logic [ISSUE_W*32-1:0]        ib_id_insn,
    output logic [ISSUE_W*PTAB_W-1:0]    ib_id_ptab_addr,
    output logic [ISSUE_W-1:0]           ib_id_delot_flag,
    input  logic [$clog2(ISSUE_W+1)-1:0] id_take,
    output logic [$clog2(DEPTH+1)-1:0]   ib_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int LW = $clog2(FETCH_W);
    logic [31:0]       mem_insn  [DEPTH];
    logic [31:0]       mem_pc    [DEPTH];
    logic [PTAB_W-1:0] mem_ptab  [DEPTH];
    logic              mem_delot [DEPTH];
    logic [CW-1:0]     head, tail;
    logic [CW-1:0]     off  [FETCH_W+1];
    logic [AW-1:0]     widx [FETCH_W];
    logic [31:0]       slot_pc [FETCH_W];
    logic [AW-1:0]     rd   [ISSUE_W];
    logic              kill;
    logic              enq;
    logic              unused_pc_lo;
    assign unused_pc_lo = ^fetch_pc[LW+1:0];
    assign ib_count = tail - head;
    assign ib_allin = ib_count <= CW'(DEPTH - FETCH_W);
    assign enq      = fetch_valid && ib_allin && !flush;
    // off[i] is the compacted queue slot of fetch slot i; off[FETCH_W] is the line's word count
    always_comb begin
        for (int i = 0; i <= FETCH_W; i++) begin
            off[i] = '0;
            for (int j = 0; j < i; j++)
                off[i] = off[i] + CW'(fetch_mask[j]);
        end
        for (int i = 0; i < FETCH_W; i++) begin
            slot_pc[i] = {fetch_pc[31:LW+2], LW'(i), 2'b00};
            widx[i]    = tail[AW-1:0] + off[i][AW-1:0];
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_ || flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            head <= head + CW'(id_take);
            if (enq)
                tail <= tail + off[FETCH_W];
        end
        if (enq)
            for (int i = 0; i < FETCH_W; i++)
                if (fetch_mask[i]) begin
                    mem_insn[widx[i]]  <= fetch_insn[i*32 +: 32];
                    mem_pc[widx[i]]    <= slot_pc[i];
                    mem_ptab[widx[i]]  <= (slot_pc[i] == fetch_branch_pc) ? fetch_ptab_addr : '0;
                    mem_delot[widx[i]] <= fetch_delot[i];
                end
    end
    always_comb begin
        kill             = 1'b0;
        ib_id_valid      = '0;
        ib_id_pc         = '0;
        ib_id_insn       = '0;
        ib_id_ptab_addr  = '0;
        ib_id_delot_flag = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            rd[k] = head[AW-1:0] + AW'(k);
`ifdef IB_DELOT_PAIR_EN
            if (mem_ptab[rd[k]][PTAB_W-1] && !(k == 0 && ISSUE_W == 1) &&
                !(k < ISSUE_W - 1 && CW'(k + 1) < ib_count))
                kill = 1'b1;
`endif
            if (CW'(k) < ib_count && !kill) begin
                ib_id_valid[k]                 = 1'b1;
                ib_id_pc[k*32 +: 32]           = mem_pc[rd[k]];
                ib_id_insn[k*32 +: 32]         = mem_insn[rd[k]];
                ib_id_ptab_addr[k*PTAB_W +: PTAB_W] = mem_ptab[rd[k]];
                ib_id_delot_flag[k]            = mem_delot[rd[k]];
            end
        end
    end
endmodule

// File: tb/tb_ib_queue.sv
// tb_ib_queue: directed vector table plus reset/full sequences for ib_queue (FETCH_W=4, ISSUE_W=2, DEPTH=16)
module tb_ib_queue;
    logic        clk = 1'b0;
    logic        rst_, flush, fetch_valid;
    logic [31:0] fetch_pc, fetch_branch_pc;
    logic [127:0] fetch_insn;
    logic [3:0]  fetch_mask, fetch_delot;
    logic [4:0]  fetch_ptab_addr;
    logic        ib_allin;
    logic [1:0]  ib_id_valid, ib_id_delot_flag, id_take;
    logic [63:0] ib_id_pc, ib_id_insn;
    logic [9:0]  ib_id_ptab_addr;
    logic [4:0]  ib_count;
    int total = 0;
    int bad = 0;

    ib_queue dut (
        .clk(clk), .rst_(rst_), .flush(flush), .fetch_valid(fetch_valid),
        .fetch_pc(fetch_pc), .fetch_insn(fetch_insn), .fetch_mask(fetch_mask),
        .fetch_delot(fetch_delot), .fetch_ptab_addr(fetch_ptab_addr),
        .fetch_branch_pc(fetch_branch_pc), .ib_allin(ib_allin),
        .ib_id_valid(ib_id_valid), .ib_id_pc(ib_id_pc), .ib_id_insn(ib_id_insn),
        .ib_id_ptab_addr(ib_id_ptab_addr), .ib_id_delot_flag(ib_id_delot_flag),
        .id_take(id_take), .ib_count(ib_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst_ && !flush && 32'(id_take) > $countones(ib_id_valid)) begin
            bad++;
            $display("FAIL take_legal got=%0d want<=%0d", id_take, $countones(ib_id_valid));
        end

    typedef struct {
        logic fl, fv;
        logic [31:0] pc;
        logic [3:0] mask, dl_in;
        logic [1:0] take;
        logic [31:0] bpc;
        logic [4:0] cnt;
        logic [1:0] vld;
        logic [31:0] pc0, pc1;
        logic [4:0] p0, p1;
        logic [1:0] dl;
        logic allin, pb;
    } vec_t;

    vec_t v[$];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic fv, input logic [31:0] pc, input logic [3:0] mask,
                         input logic [3:0] dl_in, input logic [1:0] take, input logic [31:0] bpc);
        flush = fl;
        fetch_valid = fv;
        fetch_pc = pc;
        fetch_mask = mask;
        fetch_delot = dl_in;
        id_take = take;
        fetch_branch_pc = bpc;
        fetch_ptab_addr = 5'b10011;
        for (int i = 0; i < 4; i++)
            fetch_insn[i*32 +: 32] = {16'hC0DE, pc[15:4], 2'(i), 2'b00};
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] insn_of(input logic ok, input logic [31:0] pc);
        return ok ? {16'hC0DE, pc[15:0]} : 32'h0;
    endfunction

    initial begin
        //            fl fv pc      mask  dl    tk bpc       cnt vld pc0       pc1       p0     p1     dl     al pb
        v.push_back('{0, 1, 32'h100, 4'hF, 4'h0, 0, 32'h0,   4,  3, 32'h100, 32'h104, 5'h0,  5'h0,  2'b00, 1, 0});
        v.push_back('{0, 0, 32'h0,   4'h0, 4'h0, 2, 32'h0,   2,  3, 32'h108, 32'h10C, 5'h0,  5'h0,  2'b00, 1, 0});
        v.push_back('{0, 1, 32'h208, 4'hC, 4'h0, 2, 32'h0,   2,  3, 32'h208, 32'h20C, 5'h0,  5'h0,  2'b00, 1, 0});
        v.push_back('{0, 1, 32'h300, 4'hF, 4'h0, 0, 32'h0,   6,  3, 32'h208, 32'h20C, 5'h0,  5'h0,  2'b00, 1, 0});
        v.push_back('{0, 1, 32'h310, 4'hF, 4'h0, 0, 32'h0,   10, 3, 32'h208, 32'h20C, 5'h0,  5'h0,  2'b00, 1, 0});
        v.push_back('{0, 1, 32'h320, 4'h7, 4'h0, 0, 32'h0,   13, 3, 32'h208, 32'h20C, 5'h0,  5'h0,  2'b00, 0, 0});
        v.push_back('{0, 1, 32'h400, 4'hF, 4'h0, 2, 32'h0,   11, 3, 32'h300, 32'h304, 5'h0,  5'h0,  2'b00, 1, 0});
        v.push_back('{0, 0, 32'h0,   4'h0, 4'h0, 2, 32'h0,   9,  3, 32'h308, 32'h30C, 5'h0,  5'h0,  2'b00, 1, 0});
        v.push_back('{0, 0, 32'h0,   4'h0, 4'h0, 1, 32'h0,   8,  3, 32'h30C, 32'h310, 5'h0,  5'h0,  2'b00, 1, 0});
        v.push_back('{1, 1, 32'h500, 4'hF, 4'h0, 2, 32'h0,   0,  0, 32'h0,   32'h0,   5'h0,  5'h0,  2'b00, 1, 0});
        v.push_back('{0, 0, 32'h0,   4'h0, 4'h0, 0, 32'h0,   0,  0, 32'h0,   32'h0,   5'h0,  5'h0,  2'b00, 1, 0});
        v.push_back('{0, 1, 32'h600, 4'hF, 4'h0, 0, 32'h0,   4,  3, 32'h600, 32'h604, 5'h0,  5'h0,  2'b00, 1, 0});
        v.push_back('{0, 1, 32'h610, 4'hF, 4'h0, 0, 32'h0,   8,  3, 32'h600, 32'h604, 5'h0,  5'h0,  2'b00, 1, 0});
        v.push_back('{0, 1, 32'h620, 4'hF, 4'h0, 0, 32'h0,   12, 3, 32'h600, 32'h604, 5'h0,  5'h0,  2'b00, 1, 0});
        v.push_back('{0, 1, 32'h630, 4'h3, 4'h0, 2, 32'h0,   12, 3, 32'h608, 32'h60C, 5'h0,  5'h0,  2'b00, 1, 0});
        v.push_back('{0, 0, 32'h0,   4'h0, 4'h0, 2, 32'h0,   10, 3, 32'h610, 32'h614, 5'h0,  5'h0,  2'b00, 1, 0});
        v.push_back('{0, 0, 32'h0,   4'h0, 4'h0, 2, 32'h0,   8,  3, 32'h618, 32'h61C, 5'h0,  5'h0,  2'b00, 1, 0});
        v.push_back('{0, 0, 32'h0,   4'h0, 4'h0, 2, 32'h0,   6,  3, 32'h620, 32'h624, 5'h0,  5'h0,  2'b00, 1, 0});
        v.push_back('{0, 0, 32'h0,   4'h0, 4'h0, 2, 32'h0,   4,  3, 32'h628, 32'h62C, 5'h0,  5'h0,  2'b00, 1, 0});
        v.push_back('{0, 0, 32'h0,   4'h0, 4'h0, 2, 32'h0,   2,  3, 32'h630, 32'h634, 5'h0,  5'h0,  2'b00, 1, 0});
        v.push_back('{0, 1, 32'h700, 4'hF, 4'h0, 2, 32'h0,   4,  3, 32'h700, 32'h704, 5'h0,  5'h0,  2'b00, 1, 0});
        v.push_back('{0, 0, 32'h0,   4'h0, 4'h0, 2, 32'h0,   2,  3, 32'h708, 32'h70C, 5'h0,  5'h0,  2'b00, 1, 0});
        v.push_back('{0, 0, 32'h0,   4'h0, 4'h0, 2, 32'h0,   0,  0, 32'h0,   32'h0,   5'h0,  5'h0,  2'b00, 1, 0});
        v.push_back('{0, 1, 32'h800, 4'h0, 4'h0, 0, 32'h0,   0,  0, 32'h0,   32'h0,   5'h0,  5'h0,  2'b00, 1, 0});
        v.push_back('{0, 1, 32'h900, 4'hF, 4'h2, 0, 32'h908, 4,  3, 32'h900, 32'h904, 5'h0,  5'h0,  2'b10, 1, 0});
        v.push_back('{0, 0, 32'h0,   4'h0, 4'h0, 1, 32'h0,   3,  3, 32'h904, 32'h908, 5'h0,  5'h13, 2'b01, 1, 1});
        v.push_back('{0, 0, 32'h0,   4'h0, 4'h0, 1, 32'h0,   2,  3, 32'h908, 32'h90C, 5'h13, 5'h0,  2'b00, 1, 0});
        v.push_back('{0, 0, 32'h0,   4'h0, 4'h0, 2, 32'h0,   0,  0, 32'h0,   32'h0,   5'h0,  5'h0,  2'b00, 1, 0});
        v.push_back('{0, 1, 32'hA08, 4'hC, 4'h0, 0, 32'hA0C, 2,  3, 32'hA08, 32'hA0C, 5'h0,  5'h13, 2'b00, 1, 1});
        v.push_back('{0, 1, 32'hA10, 4'h1, 4'h1, 1, 32'h0,   2,  3, 32'hA0C, 32'hA10, 5'h13, 5'h0,  2'b10, 1, 0});

        rst_ = 1'b0;
        drive(0, 0, 32'h0, 4'h0, 4'h0, 0, 32'h0);
        tick;
        tick;
        chk("rst_count", 0, 32'(ib_count), 0);
        chk("rst_valid", 0, 32'(ib_id_valid), 0);
        chk("rst_allin", 0, 32'(ib_allin), 1);
        chk("rst_pc", 0, ib_id_pc[31:0], 0);
        rst_ = 1'b1;

        foreach (v[n]) begin
            logic [1:0] ev, ed;
            logic [31:0] e1;
            logic [4:0] ep1;
            ev = v[n].vld;
            ed = v[n].dl;
            e1 = v[n].pc1;
            ep1 = v[n].p1;
`ifdef IB_DELOT_PAIR_EN
            if (v[n].pb) begin
                ev[1] = 1'b0;
                ed[1] = 1'b0;
                e1 = '0;
                ep1 = '0;
            end
`endif
            drive(v[n].fl, v[n].fv, v[n].pc, v[n].mask, v[n].dl_in, v[n].take, v[n].bpc);
            tick;
            chk("count", n, 32'(ib_count), 32'(v[n].cnt));
            chk("valid", n, 32'(ib_id_valid), 32'(ev));
            chk("allin", n, 32'(ib_allin), 32'(v[n].allin));
            chk("pc0", n, ib_id_pc[31:0], v[n].pc0);
            chk("pc1", n, ib_id_pc[63:32], e1);
            chk("insn0", n, ib_id_insn[31:0], insn_of(ev[0], v[n].pc0));
            chk("insn1", n, ib_id_insn[63:32], insn_of(ev[1], e1));
            chk("ptab0", n, 32'(ib_id_ptab_addr[4:0]), 32'(v[n].p0));
            chk("ptab1", n, 32'(ib_id_ptab_addr[9:5]), 32'(ep1));
            chk("delot", n, 32'(ib_id_delot_flag), 32'(ed));
        end

        rst_ = 1'b0;
        drive(0, 1, 32'hB00, 4'hF, 4'h0, 0, 32'h0);
        tick;
        chk("midrst_count", 0, 32'(ib_count), 0);
        chk("midrst_valid", 0, 32'(ib_id_valid), 0);
        chk("midrst_allin", 0, 32'(ib_allin), 1);
        chk("midrst_pc1", 0, ib_id_pc[63:32], 0);
        rst_ = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 32'hB00 + 32'(i) * 32'h10, 4'hF, 4'h0, 0, 32'h0);
            tick;
            chk("fill_count", i, 32'(ib_count), 32'(4 * (i + 1)));
        end
        chk("full_allin", 0, 32'(ib_allin), 0);
        chk("full_pc0", 0, ib_id_pc[31:0], 32'hB00);
        chk("full_pc1", 0, ib_id_pc[63:32], 32'hB04);
        drive(0, 1, 32'hB40, 4'hF, 4'h0, 2, 32'h0);
        tick;
        chk("fullblk_count", 0, 32'(ib_count), 14);
        chk("fullblk_allin", 0, 32'(ib_allin), 0);
        chk("fullblk_pc0", 0, ib_id_pc[31:0], 32'hB08);
        chk("fullblk_pc1", 0, ib_id_pc[63:32], 32'hB0C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
